// File: rtl/bcd_pkg.sv
// Shared BCD constants, the digit operation encoding and nibble helper functions.
package bcd_pkg;

    localparam int unsigned NIB_W = 4;

    localparam logic [NIB_W-1:0] BCD_MAX = 4'd9;
    localparam logic [NIB_W-1:0] BCD_MIN = 4'd0;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_STEP = 2'd1,
        OP_LOAD = 2'd2,
        OP_CLR  = 2'd3
    } digit_op_e;

    // Clamp an arbitrary nibble into the valid BCD range.
    function automatic logic [NIB_W-1:0] bcd_sat(input logic [NIB_W-1:0] nib);
        return (nib > BCD_MAX) ? BCD_MAX : nib;
    endfunction

    // One BCD step with wrap; out-of-range values are treated as already at the limit.
    function automatic logic [NIB_W-1:0] bcd_next(input logic [NIB_W-1:0] nib,
                                                  input logic             up);
        if (up) begin
            return (nib >= BCD_MAX) ? BCD_MIN : NIB_W'(nib + 4'd1);
        end
        return ((nib == BCD_MIN) || (nib > BCD_MAX)) ? BCD_MAX : NIB_W'(nib - 4'd1);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One 4-bit BCD cell: clear, saturating load, wrap-around step and limit flags.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             up_dn,
    input  logic             sclr,
    input  logic             load,
    input  logic [NIB_W-1:0] ld_nib,
    input  logic [NIB_W-1:0] rst_nib,
    output logic [NIB_W-1:0] d,
    output logic             at_max,
    output logic             at_min
);

    logic [NIB_W-1:0] r_d;
    logic [NIB_W-1:0] w_d_nxt;
    digit_op_e        w_op;

    // Edge priority: clear, then load, then step.
    always_comb begin
        w_op = OP_HOLD;
        if (sclr) begin
            w_op = OP_CLR;
        end else if (load) begin
            w_op = OP_LOAD;
        end else if (step) begin
            w_op = OP_STEP;
        end
    end

    always_comb begin
        w_d_nxt = r_d;
        case (w_op)
            OP_CLR:  w_d_nxt = BCD_MIN;
            OP_LOAD: w_d_nxt = bcd_sat(ld_nib);
            OP_STEP: w_d_nxt = bcd_next(r_d, up_dn);
            default: w_d_nxt = r_d;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_d <= rst_nib;
        end else begin
            r_d <= w_d_nxt;
        end
    end

    assign d      = r_d;
    assign at_max = (r_d == BCD_MAX);
    assign at_min = (r_d == BCD_MIN);

endmodule

// File: rtl/bcd_counter_ndigit.sv
// N-digit BCD up/down counter with clear, saturating load, cascade carry/borrow and sticky wrap flag.
module bcd_counter_ndigit
    import bcd_pkg::*;
#(
    parameter int unsigned             DIGITS  = 3,
    parameter logic [4*DIGITS-1:0]     RST_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cin,
    input  logic                      up_dn,
    input  logic                      sclr,
    input  logic                      load,
    input  logic [NIB_W*DIGITS-1:0]   load_val,
    output logic [NIB_W*DIGITS-1:0]   q,
    output logic                      cout,
    output logic                      ovf
);

    localparam int unsigned Q_W = NIB_W * DIGITS;

    logic [DIGITS-1:0] w_at_max;
    logic [DIGITS-1:0] w_at_min;
    logic [DIGITS-1:0] w_step;
    logic [Q_W-1:0]    w_q;
    logic              w_wrap;
    logic              r_ovf;

    // A digit steps only when every lower digit is at its wrap limit for the current direction.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        localparam logic [NIB_W-1:0] RST_NIB = bcd_sat(RST_VAL[NIB_W*g +: NIB_W]);

        if (g == 0) begin : g_lsd
            assign w_step[g] = cin;
        end else begin : g_upper
            assign w_step[g] = w_step[g-1] & (up_dn ? w_at_max[g-1] : w_at_min[g-1]);
        end

        bcd_digit u_digit (
            .clk     (clk),
            .rst     (rst),
            .step    (w_step[g]),
            .up_dn   (up_dn),
            .sclr    (sclr),
            .load    (load),
            .ld_nib  (load_val[NIB_W*g +: NIB_W]),
            .rst_nib (RST_NIB),
            .d       (w_q[NIB_W*g +: NIB_W]),
            .at_max  (w_at_max[g]),
            .at_min  (w_at_min[g])
        );
    end

    assign w_wrap = up_dn ? (&w_at_max) : (&w_at_min);
    assign cout   = cin & ~sclr & ~load & w_wrap;

    // Sticky wrap flag; only reset, clear or load drop it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (sclr || load) begin
            r_ovf <= 1'b0;
        end else if (cout) begin
            r_ovf <= 1'b1;
        end
    end

    assign q   = w_q;
    assign ovf = r_ovf;

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Scoreboard bench for bcd_counter_ndigit: decimal reference model, expected q/ovf queued per edge.
module tb_bcd_counter_ndigit;

    logic        clk;
    logic        rst;
    logic        rst_b;
    logic        cin;
    logic        up_dn;
    logic        sclr;
    logic        load;
    logic [11:0] load_val;
    logic [11:0] q;
    logic [11:0] q_b;
    logic        cout;
    logic        cout_b;
    logic        ovf;
    logic        ovf_b;

    typedef struct packed {
        logic [11:0] q;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks;
    int   n_errors;
    int   m_q;
    bit   m_ovf;

    bcd_counter_ndigit #(.DIGITS(3), .RST_VAL(12'h000)) dut (
        .clk(clk), .rst(rst), .cin(cin), .up_dn(up_dn), .sclr(sclr), .load(load),
        .load_val(load_val), .q(q), .cout(cout), .ovf(ovf)
    );

    bcd_counter_ndigit #(.DIGITS(3), .RST_VAL(12'h500)) dut_b (
        .clk(clk), .rst(rst_b), .cin(cin), .up_dn(up_dn), .sclr(sclr), .load(load),
        .load_val(load_val), .q(q_b), .cout(cout_b), .ovf(ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    function automatic int bcd2int(input logic [11:0] v);
        return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [11:0] int2bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic logic [11:0] sat12(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        for (int i = 0; i < 3; i++) begin
            if (r[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    function automatic bit model_cout();
        return cin && !sclr && !load && (up_dn ? (m_q == 999) : (m_q == 0));
    endfunction

    task automatic set_in(input logic c, input logic u, input logic s, input logic l,
                          input logic [11:0] lv);
        cin = c; up_dn = u; sclr = s; load = l; load_val = lv;
        #1;
    endtask

    // Advance the model for the current inputs, queue the expectation, then clock the DUT.
    task automatic tick();
        exp_t x;
        if (sclr) begin
            m_q = 0; m_ovf = 1'b0;
        end else if (load) begin
            m_q = bcd2int(sat12(load_val)); m_ovf = 1'b0;
        end else if (cin) begin
            if (model_cout()) m_ovf = 1'b1;
            m_q = up_dn ? (m_q + 1) % 1000 : (m_q + 999) % 1000;
        end
        x.q = int2bcd(m_q);
        x.ovf = m_ovf;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst_b = 1'b1;
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        rst = 1'b0; rst_b = 1'b0;
        #2;
        m_q = 0; m_ovf = 1'b0;
        n_checks++;
        if (q !== 12'h000) begin n_errors++; $display("FAIL reset_q got %h exp 000", q); end
        n_checks++;
        if (ovf !== 1'b0) begin n_errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
        n_checks++;
        if (cout !== 1'b0) begin n_errors++; $display("FAIL reset_cout got %b exp 0", cout); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_up_wrap();
        for (int i = 0; i < 1000; i++) begin
            set_in(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
            n_checks++;
            if (cout !== model_cout()) begin
                n_errors++; $display("FAIL up_cout step %0d got %b exp %b", i, cout, model_cout());
            end
            tick();
            e = sb.pop_front();
            n_checks++;
            if (q !== e.q || ovf !== e.ovf) begin
                n_errors++; $display("FAIL up_q step %0d got %h/%b exp %h/%b", i, q, ovf, e.q, e.ovf);
            end
        end
        n_checks++;
        if (q !== 12'h000 || ovf !== 1'b1) begin
            n_errors++; $display("FAIL up_wrap_end got %h/%b exp 000/1", q, ovf);
        end
    endtask

    task automatic test_down_borrow();
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 12'h001);
        tick();
        e = sb.pop_front();
        n_checks++;
        if (q !== e.q || ovf !== e.ovf) begin
            n_errors++; $display("FAIL down_load got %h/%b exp %h/%b", q, ovf, e.q, e.ovf);
        end
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
            n_checks++;
            if (cout !== model_cout()) begin
                n_errors++; $display("FAIL down_cout step %0d got %b exp %b", i, cout, model_cout());
            end
            tick();
            e = sb.pop_front();
            n_checks++;
            if (q !== e.q || ovf !== e.ovf) begin
                n_errors++; $display("FAIL down_q step %0d got %h/%b exp %h/%b", i, q, ovf, e.q, e.ovf);
            end
        end
        n_checks++;
        if (q !== 12'h999 || ovf !== 1'b1) begin
            n_errors++; $display("FAIL down_borrow_end got %h/%b exp 999/1", q, ovf);
        end
    endtask

    task automatic test_load_sat();
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 12'hA5F);
        tick();
        e = sb.pop_front();
        n_checks++;
        if (q !== e.q || ovf !== e.ovf) begin
            n_errors++; $display("FAIL load_sat got %h/%b exp %h/%b", q, ovf, e.q, e.ovf);
        end
        n_checks++;
        if (q !== 12'h959) begin n_errors++; $display("FAIL load_sat_abs got %h exp 959", q); end
    endtask

    task automatic test_priority_hold();
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 12'h123);
        tick();
        e = sb.pop_front();
        n_checks++;
        if (q !== e.q || q !== 12'h000) begin
            n_errors++; $display("FAIL sclr_over_load got %h exp %h", q, e.q);
        end
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 12'h999);
        tick();
        e = sb.pop_front();
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 12'h250);
        n_checks++;
        if (cout !== 1'b0) begin n_errors++; $display("FAIL load_masks_cout got %b exp 0", cout); end
        tick();
        e = sb.pop_front();
        n_checks++;
        if (q !== e.q || ovf !== e.ovf) begin
            n_errors++; $display("FAIL load_over_cin got %h/%b exp %h/%b", q, ovf, e.q, e.ovf);
        end
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 12'h999);
        tick();
        e = sb.pop_front();
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
        n_checks++;
        if (cout !== 1'b0) begin n_errors++; $display("FAIL sclr_masks_cout got %b exp 0", cout); end
        tick();
        e = sb.pop_front();
        n_checks++;
        if (q !== e.q || ovf !== e.ovf) begin
            n_errors++; $display("FAIL sclr_over_cin got %h/%b exp %h/%b", q, ovf, e.q, e.ovf);
        end
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 12'h437);
        tick();
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 1'(i % 2), 1'b0, 1'b0, 12'h888);
            tick();
            e = sb.pop_front();
            n_checks++;
            if (q !== e.q || q !== 12'h437) begin
                n_errors++; $display("FAIL hold cycle %0d got %h exp %h", i, q, e.q);
            end
        end
    endtask

    task automatic test_dir_flip();
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 12'h199);
        tick();
        e = sb.pop_front();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
        tick();
        e = sb.pop_front();
        n_checks++;
        if (q !== e.q || q !== 12'h200) begin
            n_errors++; $display("FAIL flip_up got %h exp %h", q, e.q);
        end
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
        tick();
        e = sb.pop_front();
        n_checks++;
        if (q !== e.q || q !== 12'h199) begin
            n_errors++; $display("FAIL flip_down got %h exp %h", q, e.q);
        end
    endtask

    task automatic test_mid_reset();
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 12'h995);
        tick();
        e = sb.pop_front();
        for (int i = 0; i < 7; i++) begin
            set_in(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
            tick();
            e = sb.pop_front();
            n_checks++;
            if (q !== e.q || ovf !== e.ovf) begin
                n_errors++; $display("FAIL pre_rst step %0d got %h/%b exp %h/%b", i, q, ovf, e.q, e.ovf);
            end
        end
        #2;
        rst = 1'b0;
        #1;
        m_q = 0; m_ovf = 1'b0;
        n_checks++;
        if (q !== 12'h000 || ovf !== 1'b0) begin
            n_errors++; $display("FAIL async_rst got %h/%b exp 000/0", q, ovf);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (q !== 12'h000) begin n_errors++; $display("FAIL rst_hold got %h exp 000", q); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        e = sb.pop_front();
        n_checks++;
        if (q !== e.q || q !== 12'h001) begin
            n_errors++; $display("FAIL rst_resume got %h exp %h", q, e.q);
        end
    endtask

    task automatic test_rstval500();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
        n_checks++;
        if (q_b !== 12'h500 || ovf_b !== 1'b0 || cout_b !== 1'b0) begin
            n_errors++; $display("FAIL rstval_hold got %h/%b/%b exp 500/0/0", q_b, ovf_b, cout_b);
        end
        @(negedge clk);
        rst_b = 1'b1;
        tick();
        e = sb.pop_front();
        n_checks++;
        if (q_b !== 12'h501) begin n_errors++; $display("FAIL rstval_first got %h exp 501", q_b); end
        n_checks++;
        if (q !== e.q) begin n_errors++; $display("FAIL rstval_main got %h exp %h", q, e.q); end
        tick();
        e = sb.pop_front();
        n_checks++;
        if (q_b !== 12'h502) begin n_errors++; $display("FAIL rstval_second got %h exp 502", q_b); end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_up_wrap();
        test_down_borrow();
        test_load_sat();
        test_priority_hold();
        test_dir_flip();
        test_mid_reset();
        test_rstval500();
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++; $display("FAIL scoreboard_drain left %0d exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
